// File: rtl/asmi_arbiter.sv
// Two-port round-robin arbiter in front of the ASMI flash Avalon-MM slave.
// Ownership is held for a whole burst; reads stay locked until the last beat or a watchdog abort.
module asmi_arbiter #(
    parameter int unsigned ADDR_W  = 26,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned BURST_W = 7,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic               clock,
    input  logic               reset,

    input  logic               s0_read,
    input  logic               s0_write,
    input  logic [ADDR_W-1:0]  s0_address,
    input  logic [BURST_W-1:0] s0_burstcount,
    input  logic [DATA_W-1:0]  s0_writedata,
    output logic               s0_waitrequest,
    output logic [DATA_W-1:0]  s0_readdata,
    output logic               s0_readdatavalid,

    input  logic               s1_read,
    input  logic               s1_write,
    input  logic [ADDR_W-1:0]  s1_address,
    input  logic [BURST_W-1:0] s1_burstcount,
    input  logic [DATA_W-1:0]  s1_writedata,
    output logic               s1_waitrequest,
    output logic [DATA_W-1:0]  s1_readdata,
    output logic               s1_readdatavalid,

    output logic               asmi_amm_read,
    output logic               asmi_amm_write,
    output logic [ADDR_W-1:0]  asmi_amm_address,
    output logic [BURST_W-1:0] asmi_amm_burstcount,
    output logic [DATA_W-1:0]  asmi_amm_writedata,
    input  logic               asmi_amm_waitrequest,
    input  logic [DATA_W-1:0]  asmi_amm_readdata,
    input  logic               asmi_amm_readdatavalid,

    output logic               owner,
    output logic               busy,
    output logic               err_timeout
);

    localparam int unsigned    WD_W  = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WdMax = WD_W'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StCmd, StWrData, StRdWait} state_e;

    state_e             state_q, state_d;
    logic               owner_q, owner_d;
    logic               last_grant_q, last_grant_d;
    logic               err_q, err_d;
    logic [BURST_W-1:0] beats_q, beats_d;
    logic [WD_W-1:0]    wdog_q, wdog_d;

    logic               req0, req1;
    logic               sel_read, sel_write;
    logic [BURST_W-1:0] sel_burst, burst_eff;

    assign req0      = s0_read | s0_write;
    assign req1      = s1_read | s1_write;
    assign sel_read  = owner_q ? s1_read : s0_read;
    assign sel_write = owner_q ? s1_write : s0_write;
    assign sel_burst = owner_q ? s1_burstcount : s0_burstcount;
    // A zero burstcount still moves one beat; it is forwarded unchanged.
    assign burst_eff = (sel_burst == '0) ? BURST_W'(1) : sel_burst;

    assign asmi_amm_address    = owner_q ? s1_address : s0_address;
    assign asmi_amm_burstcount = sel_burst;
    assign asmi_amm_writedata  = owner_q ? s1_writedata : s0_writedata;

    assign s0_readdata = asmi_amm_readdata;
    assign s1_readdata = asmi_amm_readdata;
    assign owner       = owner_q;
    assign busy        = (state_q != StIdle);
    assign err_timeout = err_q;

    always_comb begin
        state_d          = state_q;
        owner_d          = owner_q;
        last_grant_d     = last_grant_q;
        beats_d          = beats_q;
        wdog_d           = wdog_q;
        err_d            = err_q;
        asmi_amm_read    = 1'b0;
        asmi_amm_write   = 1'b0;
        s0_waitrequest   = 1'b1;
        s1_waitrequest   = 1'b1;
        s0_readdatavalid = 1'b0;
        s1_readdatavalid = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req0 | req1) begin
                    owner_d      = (req0 & req1) ? ~last_grant_q : req1;
                    last_grant_d = owner_d;
                    state_d      = StCmd;
                end
            end
            StCmd: begin
                asmi_amm_read  = sel_read;
                asmi_amm_write = sel_write & ~sel_read;
                if (owner_q) s1_waitrequest = asmi_amm_waitrequest;
                else         s0_waitrequest = asmi_amm_waitrequest;
                if ((sel_read | sel_write) && !asmi_amm_waitrequest) begin
                    if (sel_read) begin
                        beats_d = burst_eff;
                        wdog_d  = '0;
                        state_d = StRdWait;
                    end else begin
                        beats_d = burst_eff - BURST_W'(1);
                        state_d = (burst_eff == BURST_W'(1)) ? StIdle : StWrData;
                    end
                end else if (!(sel_read | sel_write)) begin
                    state_d = StIdle;
                end
            end
            StWrData: begin
                asmi_amm_write = sel_write;
                if (owner_q) s1_waitrequest = asmi_amm_waitrequest;
                else         s0_waitrequest = asmi_amm_waitrequest;
                if (sel_write && !asmi_amm_waitrequest) begin
                    beats_d = beats_q - BURST_W'(1);
                    if (beats_q == BURST_W'(1)) state_d = StIdle;
                end
            end
            StRdWait: begin
                if (owner_q) s1_readdatavalid = asmi_amm_readdatavalid;
                else         s0_readdatavalid = asmi_amm_readdatavalid;
                // A beat wins over a simultaneous watchdog expiry.
                if (asmi_amm_readdatavalid) begin
                    beats_d = beats_q - BURST_W'(1);
                    wdog_d  = '0;
                    if (beats_q == BURST_W'(1)) state_d = StIdle;
                end else begin
                    wdog_d = (wdog_q == WdMax) ? wdog_q : wdog_q + WD_W'(1);
                    if (wdog_q >= WdMax - WD_W'(1)) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            beats_q      <= '0;
            wdog_q       <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            beats_q      <= beats_d;
            wdog_q       <= wdog_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: tb/tb_asmi_arbiter.sv
// Directed bench for asmi_arbiter: transaction-level model checked every cycle,
// plus literal expectations per scenario.
module tb_asmi_arbiter;

    localparam int unsigned ADDR_W  = 26;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned BURST_W = 7;
    localparam int unsigned TMO     = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic s0_read = 0, s0_write = 0, s1_read = 0, s1_write = 0;
    logic [ADDR_W-1:0]  s0_address = '0, s1_address = '0;
    logic [BURST_W-1:0] s0_burstcount = '0, s1_burstcount = '0;
    logic [DATA_W-1:0]  s0_writedata = '0, s1_writedata = '0;
    logic s0_waitrequest, s1_waitrequest, s0_readdatavalid, s1_readdatavalid;
    logic [DATA_W-1:0] s0_readdata, s1_readdata;
    logic asmi_amm_read, asmi_amm_write;
    logic [ADDR_W-1:0]  asmi_amm_address;
    logic [BURST_W-1:0] asmi_amm_burstcount;
    logic [DATA_W-1:0]  asmi_amm_writedata;
    logic asmi_amm_waitrequest = 0, asmi_amm_readdatavalid = 0;
    logic [DATA_W-1:0] asmi_amm_readdata = '0;
    logic owner, busy, err_timeout;

    asmi_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W), .TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset),
        .s0_read(s0_read), .s0_write(s0_write), .s0_address(s0_address),
        .s0_burstcount(s0_burstcount), .s0_writedata(s0_writedata),
        .s0_waitrequest(s0_waitrequest), .s0_readdata(s0_readdata),
        .s0_readdatavalid(s0_readdatavalid),
        .s1_read(s1_read), .s1_write(s1_write), .s1_address(s1_address),
        .s1_burstcount(s1_burstcount), .s1_writedata(s1_writedata),
        .s1_waitrequest(s1_waitrequest), .s1_readdata(s1_readdata),
        .s1_readdatavalid(s1_readdatavalid),
        .asmi_amm_read(asmi_amm_read), .asmi_amm_write(asmi_amm_write),
        .asmi_amm_address(asmi_amm_address), .asmi_amm_burstcount(asmi_amm_burstcount),
        .asmi_amm_writedata(asmi_amm_writedata), .asmi_amm_waitrequest(asmi_amm_waitrequest),
        .asmi_amm_readdata(asmi_amm_readdata), .asmi_amm_readdatavalid(asmi_amm_readdatavalid),
        .owner(owner), .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Transaction model: phase 0 idle, 1 command offered, 2 write data, 3 read return.
    int m_phase = 0;
    bit m_owner = 0, m_last = 1, m_err = 0;
    int m_left = 0, m_quiet = 0;

    function automatic bit own_rd();  return m_owner ? s1_read : s0_read;   endfunction
    function automatic bit own_wr();  return m_owner ? s1_write : s0_write; endfunction
    function automatic int own_len();
        int b;
        b = m_owner ? int'(s1_burstcount) : int'(s0_burstcount);
        return (b == 0) ? 1 : b;
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            m_phase = 0; m_owner = 0; m_last = 1; m_err = 0; m_left = 0; m_quiet = 0;
        end else begin
            case (m_phase)
                0: if (s0_read | s0_write | s1_read | s1_write) begin
                    if ((s0_read | s0_write) && (s1_read | s1_write)) m_owner = !m_last;
                    else m_owner = (s1_read | s1_write);
                    m_last  = m_owner;
                    m_phase = 1;
                end
                1: if ((own_rd() || own_wr()) && !asmi_amm_waitrequest) begin
                    if (own_rd()) begin
                        m_left = own_len(); m_quiet = 0; m_phase = 3;
                    end else begin
                        m_left  = own_len() - 1;
                        m_phase = (m_left == 0) ? 0 : 2;
                    end
                end else if (!(own_rd() || own_wr())) m_phase = 0;
                2: if (own_wr() && !asmi_amm_waitrequest) begin
                    m_left--;
                    if (m_left == 0) m_phase = 0;
                end
                3: if (asmi_amm_readdatavalid) begin
                    m_left--; m_quiet = 0;
                    if (m_left == 0) m_phase = 0;
                end else begin
                    m_quiet++;
                    if (m_quiet >= int'(TMO)) begin m_err = 1; m_phase = 0; end
                end
                default: m_phase = 0;
            endcase
        end
    end

    int cnt0 = 0, cnt1 = 0, wacc = 0;

    always @(negedge clock) begin
        bit pass;
        if (chk_en) begin
            pass = (m_phase == 1) || (m_phase == 2);
            check("cyc_busy", busy, m_phase != 0);
            check("cyc_owner", owner, m_owner);
            check("cyc_err", err_timeout, m_err);
            check("cyc_amm_read", asmi_amm_read, (m_phase == 1) && own_rd());
            check("cyc_amm_write", asmi_amm_write,
                  ((m_phase == 1) && own_wr() && !own_rd()) || ((m_phase == 2) && own_wr()));
            check("cyc_s0_wait", s0_waitrequest, (pass && !m_owner) ? asmi_amm_waitrequest : 1'b1);
            check("cyc_s1_wait", s1_waitrequest, (pass && m_owner) ? asmi_amm_waitrequest : 1'b1);
            check("cyc_s0_rdv", s0_readdatavalid,
                  (m_phase == 3 && !m_owner) ? asmi_amm_readdatavalid : 1'b0);
            check("cyc_s1_rdv", s1_readdatavalid,
                  (m_phase == 3 && m_owner) ? asmi_amm_readdatavalid : 1'b0);
            check("cyc_s0_rdata", s0_readdata, asmi_amm_readdata);
            check("cyc_s1_rdata", s1_readdata, asmi_amm_readdata);
            if (pass) begin
                check("cyc_addr", asmi_amm_address, m_owner ? s1_address : s0_address);
                check("cyc_bc", asmi_amm_burstcount, m_owner ? s1_burstcount : s0_burstcount);
                check("cyc_wdata", asmi_amm_writedata, m_owner ? s1_writedata : s0_writedata);
            end
        end
        cnt0 += int'(s0_readdatavalid === 1'b1);
        cnt1 += int'(s1_readdatavalid === 1'b1);
        wacc += int'(asmi_amm_write === 1'b1 && asmi_amm_waitrequest === 1'b0);
    end

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    int c0, c1, w0, acc, k;

    initial begin
        // Reset with a stray beat present: nothing may leak to the ports.
        asmi_amm_readdatavalid = 1'b1;
        tick();
        chk_en = 1;
        tick();
        check("rst_busy", busy, 0);
        check("rst_owner", owner, 0);
        check("rst_err", err_timeout, 0);
        check("rst_waits", {s0_waitrequest, s1_waitrequest}, 2'b11);
        check("rst_strobes", {asmi_amm_read, asmi_amm_write}, 2'b00);
        check("rst_rdv", {s0_readdatavalid, s1_readdatavalid}, 2'b00);
        reset = 1'b0;
        asmi_amm_readdatavalid = 1'b0;
        tick();

        // Port-0 read of 4, no stall.
        s0_read = 1; s0_burstcount = 7'd4; s0_address = 26'h100;
        tick();
        check("t1_master_read", asmi_amm_read, 1);
        check("t1_addr", asmi_amm_address, 26'h100);
        tick();
        s0_read = 0;
        c0 = cnt0; c1 = cnt1;
        for (int i = 0; i < 4; i++) begin
            asmi_amm_readdatavalid = 1; asmi_amm_readdata = 32'hA000 + i;
            tick();
        end
        asmi_amm_readdatavalid = 0;
        check("t1_busy_after", busy, 0);
        check("t1_s0_beats", cnt0 - c0, 4);
        check("t1_s1_beats", cnt1 - c1, 0);

        // Tie from reset, 64-beat reads on both ports.
        do_reset();
        s0_read = 1; s0_burstcount = 7'd64; s0_address = 26'h200;
        s1_read = 1; s1_burstcount = 7'd64; s1_address = 26'h300;
        tick();
        check("t2_first_owner", owner, 0);
        check("t2_first_addr", asmi_amm_address, 26'h200);
        tick();
        s0_read = 0;
        c0 = cnt0; c1 = cnt1;
        for (int i = 0; i < 64; i++) begin
            asmi_amm_readdatavalid = 1; asmi_amm_readdata = 32'hB000 + i;
            #1 check("t2_s1_stalled", s1_waitrequest, 1);
            tick();
        end
        asmi_amm_readdatavalid = 0;
        check("t2_gap_read", asmi_amm_read, 0);
        check("t2_gap_busy", busy, 0);
        tick();
        check("t2_p1_read", asmi_amm_read, 1);
        check("t2_p1_owner", owner, 1);
        check("t2_p1_addr", asmi_amm_address, 26'h300);
        tick();
        s1_read = 0;
        for (int i = 0; i < 64; i++) begin
            asmi_amm_readdatavalid = 1; asmi_amm_readdata = 32'hC000 + i;
            tick();
        end
        asmi_amm_readdatavalid = 0;
        check("t2_s0_beats", cnt0 - c0, 64);
        check("t2_s1_beats", cnt1 - c1, 64);

        // Port-1 write of 8 with waitrequest toggling.
        s1_write = 1; s1_burstcount = 7'd8; s1_address = 26'h400;
        w0 = wacc;
        tick();
        acc = 0; k = 0;
        while (acc < 8 && k < 40) begin
            asmi_amm_waitrequest = (k % 2 == 0);
            s1_writedata = 32'hD000 + k;
            #1 check("t3_s0_wait", s0_waitrequest, 1);
            tick();
            if (!asmi_amm_waitrequest) acc++;
            k++;
        end
        check("t3_accepts_in_budget", acc, 8);
        asmi_amm_waitrequest = 0; s1_write = 0;
        check("t3_idle", busy, 0);
        check("t3_master_accepts", wacc - w0, 8);
        tick();

        // Port-0 read of 2, one beat only, watchdog of 16.
        s0_read = 1; s0_burstcount = 7'd2;
        tick();
        tick();
        s0_read = 0;
        asmi_amm_readdatavalid = 1;
        tick();
        asmi_amm_readdatavalid = 0;
        for (int i = 0; i < 15; i++) tick();
        check("t4_no_err_yet", {err_timeout, busy}, 2'b01);
        tick();
        check("t4_err_set", err_timeout, 1);
        check("t4_idle", busy, 0);
        c1 = cnt1;
        s1_read = 1; s1_burstcount = 7'd1;
        tick();
        tick();
        s1_read = 0;
        asmi_amm_readdatavalid = 1;
        tick();
        asmi_amm_readdatavalid = 0;
        check("t4_p1_done", busy, 0);
        check("t4_p1_beats", cnt1 - c1, 1);
        check("t4_err_sticky", err_timeout, 1);
        asmi_amm_readdatavalid = 1;
        #1 check("t4_stray", {s0_readdatavalid, s1_readdatavalid}, 2'b00);
        tick();
        asmi_amm_readdatavalid = 0;

        // Reset during beat 3 of a port-1 64-beat read.
        s1_read = 1; s1_burstcount = 7'd64;
        tick();
        tick();
        s1_read = 0;
        for (int i = 0; i < 2; i++) begin
            asmi_amm_readdatavalid = 1;
            tick();
        end
        reset = 1;
        tick();
        reset = 0;
        check("t5_waits", {s0_waitrequest, s1_waitrequest}, 2'b11);
        check("t5_busy", busy, 0);
        check("t5_owner", owner, 0);
        check("t5_err_cleared", err_timeout, 0);
        c0 = cnt0; c1 = cnt1;
        for (int i = 0; i < 61; i++) tick();
        asmi_amm_readdatavalid = 0;
        check("t5_no_leak", (cnt0 - c0) + (cnt1 - c1), 0);

        // Port-0 write with burstcount 0.
        s0_write = 1; s0_burstcount = 7'd0; s0_writedata = 32'hE0E0;
        w0 = wacc;
        tick();
        check("t6_write_fwd", {asmi_amm_write, asmi_amm_burstcount}, {1'b1, 7'd0});
        tick();
        s0_write = 0;
        check("t6_idle", busy, 0);
        check("t6_one_beat", wacc - w0, 1);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
